// File: rtl/mux_rr_arb_pkg.sv
// rtl/mux_rr_arb_pkg.sv - shared types and round-robin search helper for mux_rr_arb
// Optional burst lock is enabled by defining MUX_RR_LOCK_EN.
package mux_rr_pkg;

  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[0..n-1], searching upward from ptr and wrapping.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]     valid,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int                   n);
    rr_pick_t r;
    int       idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n && !r.found) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.idx   = idx[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// rtl/mux_rr_arb_if.sv - N-channel producer bundle plus single sink port of mux_rr_arb
// Optional burst lock (MUX_RR_LOCK_EN) gives in_last its meaning.
interface mux_rr_arb_if #(
  parameter int W = 32,
  parameter int N = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_rr_arb_rr_arbiter.sv
// rtl/mux_rr_arb_rr_arbiter.sv - combinational round-robin grant with registered pointer
// Defining MUX_RR_LOCK_EN adds the IDLE/LOCKED burst-lock FSM.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  last,
  input  logic          take,
  output logic          grant_valid,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_n;
  logic [SW-1:0] next_ptr;
  rr_pick_t      pick;

  assign pick     = rr_pick(MAX_N'(valid), MAX_IDX_W'(ptr_q), N);
  assign next_ptr = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;

`ifdef MUX_RR_LOCK_EN
  lock_state_t   state_q;
  lock_state_t   state_n;
  logic [SW-1:0] lock_idx_q;
  logic [SW-1:0] lock_idx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_n;
      lock_idx_q <= lock_idx_n;
      ptr_q      <= ptr_n;
    end
  end

  // A non-last beat pins the grant; the pointer only moves once the burst closes.
  always_comb begin
    state_n    = state_q;
    lock_idx_n = lock_idx_q;
    ptr_n      = ptr_q;
    if (take) begin
      if (last[grant_idx]) begin
        state_n = IDLE;
        ptr_n   = next_ptr;
      end else begin
        state_n    = LOCKED;
        lock_idx_n = grant_idx;
      end
    end
  end

  always_comb begin
    grant_valid = pick.found;
    grant_idx   = SW'(pick.idx);
    if (state_q == LOCKED) begin
      grant_valid = valid[lock_idx_q];
      grant_idx   = lock_idx_q;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_n;
    end
  end

  always_comb begin
    ptr_n = ptr_q;
    if (take) ptr_n = next_ptr;
  end

  always_comb begin
    grant_valid = pick.found;
    grant_idx   = SW'(pick.idx);
  end
`endif

endmodule

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - N-channel registered mux with round-robin arbitration and valid/ready
// Optional burst lock is enabled by defining MUX_RR_LOCK_EN.
module mux_rr_arb
  import mux_rr_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      reset,
  mux_rr_arb_if.slave bus
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;
  logic          load;
  logic          take;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;

  // The stage refills in the same cycle it drains, giving one beat per cycle.
  assign load = !out_valid_q || bus.out_ready;
  assign take = load && grant_valid && !reset;

  always_comb begin
    bus.in_ready = '0;
    if (take) bus.in_ready[grant_idx] = 1'b1;
  end

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid       (bus.in_valid),
    .last        (bus.in_last),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (take) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[int'(grant_idx)*W +: W];
        out_sel_q   <= grant_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - scoreboard bench for mux_rr_arb (expectations follow MUX_RR_LOCK_EN)
module tb_mux_rr_arb;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } beat_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  beat_t exp_q[$];

  mux_rr_arb_if #(.W(W), .N(N)) bus ();

  mux_rr_arb #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] v);
    bus.in_data[ch*W +: W] = v;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.sel  = s;
    exp_q.push_back(b);
  endtask

  // Monitor: every beat the sink accepts must match the oldest expected beat.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {32'd0, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(b.data));
        chk("out_sel", 64'(bus.out_sel), 64'(b.sel));
      end
    end
  end

`ifdef MUX_RR_LOCK_EN
  localparam int LOCK_LEN = 4;
  localparam logic [1:0] LOCK_SEQ [LOCK_LEN] = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
  localparam int LOCK_LEN = 5;
  localparam logic [1:0] LOCK_SEQ [LOCK_LEN] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`endif

  initial begin
    int b1;
    int b2;
    int g;
    int wait_cycles;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = '0;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;

    // Reset then idle
    tick();
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'h0);
    tick();
    reset        = 1'b0;
    bus.in_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out_valid", 64'(bus.out_valid), 64'h0);
      chk("idle_out_data", 64'(bus.out_data), 64'h0);
      chk("idle_out_sel", 64'(bus.out_sel), 64'h0);
      chk("idle_in_ready", 64'(bus.in_ready), 64'h0);
    end

    // Single channel
    bus.in_valid = 4'b0100;
    set_data(2, 32'hDEADBEEF);
    #1;
    chk("single_in_ready", 64'(bus.in_ready), 64'h4);
    push(32'hDEADBEEF, 2'd2);
    tick();
    bus.in_valid = 4'b0000;
    chk("single_out_valid", 64'(bus.out_valid), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Round robin with all channels valid
    for (int i = 0; i < N; i++) set_data(i, 32'(i + 1));
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_in_ready", 64'(bus.in_ready), 64'(4'b0001 << (i % 4)));
      push(32'((i % 4) + 1), 2'(i % 4));
      tick();
    end
    bus.in_valid = 4'b0000;
    tick();

    // Backpressure: hold beat from channel 1, then channel 2 wins on release
    bus.in_valid = 4'b0010;
    push(32'd2, 2'd1);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      chk("bp_out_data", 64'(bus.out_data), 64'd2);
      chk("bp_out_sel", 64'(bus.out_sel), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'h4);
    push(32'd3, 2'd2);
    tick();
    bus.in_valid = 4'b0000;
    tick();

    // Reset mid-operation discards the held beat and rewinds the pointer
    bus.in_valid = 4'b0001;
    push(32'd1, 2'd0);
    tick();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    void'(exp_q.pop_back());
    tick();
    reset = 1'b0;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1111;
    #1;
    chk("midreset_first_grant", 64'(bus.in_ready), 64'h1);
    push(32'd1, 2'd0);
    tick();
    bus.in_valid = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Burst: channel 1 sends last=0,0,1 while channel 2 stays valid
    b1 = 0;
    b2 = 0;
    for (int k = 0; k < LOCK_LEN; k++) begin
      bus.in_valid = {1'b0, 1'b1, (b1 < 3), 1'b0};
      set_data(1, 32'(32'h10 + b1));
      set_data(2, 32'(32'h20 + b2));
      bus.in_last = {1'b1, 1'b1, (b1 == 2), 1'b1};
      g = int'(LOCK_SEQ[k]);
      #1;
      chk("burst_in_ready", 64'(bus.in_ready), 64'(4'b0001 << g));
      if (g == 1) begin
        push(32'(32'h10 + b1), 2'd1);
        b1++;
      end else begin
        push(32'(32'h20 + b2), 2'd2);
        b2++;
      end
      tick();
    end
    bus.in_valid = 4'b0000;

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      tick();
      wait_cycles++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshake.
- Successor to the combinational mux2 and used wherever several producers share one sink, e.g. the I-fetch and D-access ports into the shared memory bus.
- Selection is owned by an internal fair arbiter, not by an external select line.
- Output is registered: one-cycle latency, full throughput.

Parameters:
- W, 32, data width in bits.
- N, 4, number of input channels (1..16).
- SW, (N>1 ? $clog2(N) : 1), select/index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel request.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_last  in  N  per-channel end-of-burst marker; ignored unless MUX_RR_LOCK_EN.
- in_ready  out  N  per-channel accept; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered winning data.
- out_sel  out  SW  index of the channel that produced out_data.
- out_ready  in  1  sink accept.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, lock state idle.
  - A beat held at reset is discarded.
  - in_ready is all-zero while reset is high.
- Load enable: load = !out_valid || out_ready. The stage refills in the same cycle it drains.
- Arbitration (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping N-1 -> 0.
  - The first set bit is the grant g.
  - No valid input gives no grant.
- Handshake:
  - in_ready[i] = load && grant==i && !reset.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - Inputs must hold data/valid stable until accepted. The block never drops a presented beat.
- On transfer:
  - next cycle out_valid=1, out_data=in_data[g], out_sel=g.
  - ptr <= (g+1) mod N. With N=1, ptr stays 0.
- If load with no transfer: out_valid <= 0.
- If !load: output register and ptr hold.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Fairness: with all N channels continuously valid, grants cycle 0,1,..,N-1,0.
- Simultaneous events:
  - A new request arriving in the same cycle a grant is issued does not preempt the grant.
  - The pointer advances only on an actual transfer, never on a stall.
- Backpressure: out_ready=0 with out_valid=1 holds out_data/out_sel stable and forces in_ready=0.

Optional Feature:
- MUX_RR_LOCK_EN defined (burst lock):
  - After a transfer on channel g with in_last[g]=0, the arbiter locks to g.
  - While locked, only g can be granted; other channels wait even if valid.
  - The lock releases after a transfer with in_last[g]=1. ptr then advances to g+1.
  - ptr does not advance on non-last beats.
  - Reset clears the lock.
- MUX_RR_LOCK_EN undefined:
  - in_last is unused.
  - Every beat re-arbitrates and ptr advances on every transfer.

Decomposition:
- Package mux_rr_pkg holds:
  - function rr_pick(valid, ptr), returning found flag + index.
  - localparam MAX_N = 16.
  - typedef for the lock state enum {IDLE, LOCKED}.
- One sub-module, rr_arbiter (combinational grant + registered ptr/lock), instantiated by mux_rr_arb.
- The datapath register stays in the top.

Test Plan:
- Reset then idle: hold reset 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 for 5 cycles.
- Single channel: N=4, W=32, in_valid=0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=DEADBEEF, out_sel=2.
- Round robin: all valid, channel i data = i+1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4, back-to-back.
- Backpressure: out_valid=1 with out_sel=1, drop out_ready for 3 cycles -> out_data/out_sel stable, in_ready=0000, ptr unchanged.
  - On release, the next grant is channel 2 if valid.
- Reset mid-operation: assert reset while out_valid=1 with out_ready=0 -> next cycle out_valid=0 and ptr=0.
  - After release, with all valid, the first grant is channel 0.
- Lock (MUX_RR_LOCK_EN): channel 1 sends 3 beats with in_last=0,0,1 while channel 2 is continuously valid -> out_sel 1,1,1,2.
  - Without the macro, the same stimulus gives 1,2,1,2,1.
